// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response bundle between the load-store buffer, the
// fetch unit, mem_ctrl, and the 8-bit external RAM/IO bus.
//   lsb_*  : load/store request (level) and one-cycle completion with data
//   if_*   : 4-byte instruction fetch request (level) and completion
//   mem_*  : byte-wide external bus (mem_din is the RAM read byte)
// Modports: slave = mem_ctrl, master = requesters plus the RAM side.
interface mem_ctrl_if;
  logic        lsb_en;
  logic        lsb_rw;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic [2:0]  lsb_width;
  logic        lsb_ok;
  logic [31:0] lsb_rdata;
  logic        if_en;
  logic [31:0] if_addr;
  logic        if_ok;
  logic [31:0] if_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  lsb_en, lsb_rw, lsb_addr, lsb_wdata, lsb_width,
    output lsb_ok, lsb_rdata,
    input  if_en, if_addr,
    output if_ok, if_rdata,
    input  mem_din,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output lsb_en, lsb_rw, lsb_addr, lsb_wdata, lsb_width,
    input  lsb_ok, lsb_rdata,
    output if_en, if_addr,
    input  if_ok, if_rdata,
    output mem_din,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates load/store (priority) and fetch requests and
// serialises each into little-endian byte accesses on the external bus,
// returning a one-cycle ok pulse with assembled, zero-extended data.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; low freezes all state, mem_wr forced 0
//   clear           mispredict flush; aborts an in-flight read
//   io_buffer_full  UART TX buffer full (only used with the macro below)
//   bus             mem_ctrl_if.slave: lsb_*, if_*, mem_* signals
// Build option: define MEM_CTRL_IO_STALL_EN to stall IO writes while
// io_buffer_full is high.
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       clear,
  input  logic       io_buffer_full,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t           r_state, w_next;
  logic [2:0]       r_cnt;
  logic [2:0]       r_width;
  logic [31:0]      r_base;
  logic [3:0][7:0]  r_wdata;
  logic [3:0][7:0]  r_buf;
  logic             r_owner_if;
  logic             r_lsb_ok, r_if_ok;
  logic [31:0]      r_lsb_rdata, r_if_rdata;

  logic [31:0]      w_addr;
  logic             w_is_io;
  logic             w_stall;
  logic             w_active;
  logic             w_ok_now;
  logic [1:0]       w_slot;
  logic [3:0][7:0]  w_asm;
  logic [31:0]      w_mem_a;
  logic [7:0]       w_mem_dout;
  logic             w_mem_wr;

  assign w_addr   = r_base + {29'd0, r_cnt};
  assign w_is_io  = (w_addr[17:16] == IO_BASE[17:16]);
  assign w_active = (r_cnt < r_width);
  assign w_ok_now = r_lsb_ok | r_if_ok;
  // mem_din lags the address by one cycle, so it belongs to slot cnt-1
  assign w_slot   = r_cnt[1:0] - 2'd1;

`ifdef MEM_CTRL_IO_STALL_EN
  assign w_stall = (r_state == WRITE) && w_is_io && io_buffer_full;
`else
  logic w_unused;
  assign w_stall  = 1'b0;
  assign w_unused = ^{io_buffer_full, w_is_io};
`endif

  always_comb begin
    w_asm         = r_buf;
    w_asm[w_slot] = bus.mem_din;
  end

  always_comb begin
    w_next     = r_state;
    w_mem_a    = '0;
    w_mem_dout = '0;
    w_mem_wr   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.lsb_en)     w_next = bus.lsb_rw ? WRITE : READ;
        else if (bus.if_en) w_next = READ;
      end
      READ: begin
        if (w_active) w_mem_a = w_addr;
        if (clear)         w_next = IDLE;
        else if (w_ok_now) w_next = DONE;
      end
      WRITE: begin
        if (w_active) begin
          w_mem_a    = w_addr;
          w_mem_dout = r_wdata[r_cnt[1:0]];
          w_mem_wr   = rdy & ~w_stall;
        end
        if (w_ok_now) w_next = DONE;
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_width     <= '0;
      r_base      <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_owner_if  <= 1'b0;
      r_lsb_ok    <= 1'b0;
      r_if_ok     <= 1'b0;
      r_lsb_rdata <= '0;
      r_if_rdata  <= '0;
    end else if (rdy) begin
      r_state  <= w_next;
      r_lsb_ok <= 1'b0;
      r_if_ok  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_buf <= '0;
          if (bus.lsb_en) begin
            r_base     <= bus.lsb_addr;
            r_width    <= bus.lsb_width;
            r_wdata    <= bus.lsb_wdata;
            r_owner_if <= 1'b0;
          end else if (bus.if_en) begin
            r_base     <= bus.if_addr;
            r_width    <= 3'd4;
            r_owner_if <= 1'b1;
          end
        end
        READ: begin
          if (!clear) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt != 3'd0 && r_cnt <= r_width) r_buf[w_slot] <= bus.mem_din;
            // Last slot arrives now: ok is registered, visible next cycle
            if (r_cnt == r_width) begin
              if (r_owner_if) begin
                r_if_ok    <= 1'b1;
                r_if_rdata <= w_asm;
              end else begin
                r_lsb_ok    <= 1'b1;
                r_lsb_rdata <= w_asm;
              end
            end
          end
        end
        WRITE: begin
          if (w_active && !w_stall) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == r_width - 3'd1) r_lsb_ok <= 1'b1;
          end
        end
        DONE: r_cnt <= '0;
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.mem_a     = w_mem_a;
  assign bus.mem_dout  = w_mem_dout;
  assign bus.mem_wr    = w_mem_wr;
  assign bus.lsb_ok    = r_lsb_ok;
  assign bus.lsb_rdata = r_lsb_rdata;
  assign bus.if_ok     = r_if_ok;
  assign bus.if_rdata  = r_if_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a byte RAM model,
// an ok/rdata scoreboard and logs of bus read/write cycles.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst, rdy, clear, io_buffer_full;

  mem_ctrl_if bus();

  mem_ctrl #(.IO_BASE(32'h0003_0000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .io_buffer_full(io_buffer_full), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;
  int n_ok  = 0;

  typedef struct { bit is_if; bit chk; logic [31:0] data; int cyc; } exp_t;
  typedef struct { int cyc; logic [31:0] a; logic [7:0] d; } bus_t;
  exp_t sb[$];
  bus_t wr_log[$];
  bus_t rd_log[$];

  logic [7:0] ram [0:65535];

  function automatic logic [7:0] pat(input int unsigned a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ v[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] golden(input int unsigned a, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) r[i*8 +: 8] = pat(a + i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Registered-read RAM: byte for address in cycle N appears in cycle N+1
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 65536; i++) ram[i] <= pat(i);
      ram[16'h0100] <= 8'h11;
      ram[16'h0101] <= 8'h22;
      ram[16'h0102] <= 8'h33;
      ram[16'h0103] <= 8'h44;
    end else if (bus.mem_wr) begin
      ram[bus.mem_a[15:0]] <= bus.mem_dout;
    end
    bus.mem_din <= ram[bus.mem_a[15:0]];
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.mem_wr) wr_log.push_back('{cyc, bus.mem_a, bus.mem_dout});
      else if (bus.mem_a != 32'd0) rd_log.push_back('{cyc, bus.mem_a, 8'h00});
      if (bus.lsb_ok || bus.if_ok) begin
        n_ok++;
        if (sb.size() == 0) begin
          check("unexpected_ok", {30'd0, bus.lsb_ok, bus.if_ok}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ok_owner", {30'd0, bus.lsb_ok, bus.if_ok}, e.is_if ? 32'd1 : 32'd2);
          check("ok_cycle", cyc, e.cyc);
          if (e.chk) check("rdata", e.is_if ? bus.if_rdata : bus.lsb_rdata, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ok(input int target, input string tag);
    for (int i = 0; i < 60 && n_ok < target; i++) step();
    check(tag, n_ok, target);
  endtask

  task automatic lsb_drive(input logic rw, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] w);
    bus.lsb_en    = 1'b1;
    bus.lsb_rw    = rw;
    bus.lsb_addr  = a;
    bus.lsb_wdata = wd;
    bus.lsb_width = w;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, ok0;
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    bus.lsb_en = 1'b0; bus.lsb_rw = 1'b0; bus.lsb_addr = '0;
    bus.lsb_wdata = '0; bus.lsb_width = '0;
    bus.if_en = 1'b0; bus.if_addr = '0;
    repeat (3) step();
    check("rst_mem_a", bus.mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
    check("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    check("rst_lsb_ok", {31'd0, bus.lsb_ok}, 32'd0);
    check("rst_if_ok", {31'd0, bus.if_ok}, 32'd0);
    check("rst_lsb_rdata", bus.lsb_rdata, 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    rst = 1'b0;
    step();

    // LW 0x100
    rd_log.delete();
    lsb_drive(1'b0, 32'h100, 32'd0, 3'd4);
    t = cyc;
    sb.push_back('{1'b0, 1'b1, 32'h4433_2211, t + 6});
    wait_ok(n_ok + 1, "lw_done");
    bus.lsb_en = 1'b0;
    check("lw_nreads", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
      check("lw_rd_cyc", rd_log[i].cyc, t + 1 + i);
      check("lw_rd_addr", rd_log[i].a, 32'h100 + i);
    end
    step();

    // SH 0x204
    wr_log.delete();
    lsb_drive(1'b1, 32'h204, 32'hAABB_CCDD, 3'd2);
    t = cyc;
    sb.push_back('{1'b0, 1'b0, 32'd0, t + 3});
    wait_ok(n_ok + 1, "sh_done");
    bus.lsb_en = 1'b0;
    check("sh_nwrites", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("sh_w0", {wr_log[0].cyc[15:0], wr_log[0].a[7:0], wr_log[0].d},
            {t[15:0] + 16'd1, 8'h04, 8'hDD});
      check("sh_w1", {wr_log[1].cyc[15:0], wr_log[1].a[7:0], wr_log[1].d},
            {t[15:0] + 16'd2, 8'h05, 8'hCC});
    end
    step();

    // LB 0x205 reads back the stored byte, zero-extended
    lsb_drive(1'b0, 32'h205, 32'd0, 3'd1);
    t = cyc;
    sb.push_back('{1'b0, 1'b1, 32'h0000_00CC, t + 3});
    wait_ok(n_ok + 1, "lb_done");
    bus.lsb_en = 1'b0;
    step();

    // LSB and IF together: LSB first, IF accepted two cycles after lsb_ok
    rd_log.delete();
    lsb_drive(1'b0, 32'h300, 32'd0, 3'd4);
    bus.if_en = 1'b1; bus.if_addr = 32'h1000;
    t = cyc;
    sb.push_back('{1'b0, 1'b1, golden(32'h300, 4), t + 6});
    sb.push_back('{1'b1, 1'b1, golden(32'h1000, 4), t + 14});
    ok0 = n_ok;
    wait_ok(ok0 + 1, "arb_lsb_done");
    bus.lsb_en = 1'b0;
    wait_ok(ok0 + 2, "arb_if_done");
    bus.if_en = 1'b0;
    check("arb_nreads", rd_log.size(), 8);
    if (rd_log.size() == 8) begin
      check("arb_if_first_cyc", rd_log[4].cyc, t + 9);
      check("arb_if_first_addr", rd_log[4].a, 32'h1000);
    end
    check("lsb_rdata_hold", bus.lsb_rdata, golden(32'h300, 4));
    step();

    // clear in second cycle of an IF read
    bus.if_en = 1'b1; bus.if_addr = 32'h2000;
    t = cyc;
    ok0 = n_ok;
    step();
    step();
    clear = 1'b1; bus.if_en = 1'b0;
    step();
    clear = 1'b0;
    check("clr_idle_mem_a", bus.mem_a, 32'd0);
    repeat (8) step();
    check("clr_no_ok", n_ok, ok0);
    bus.if_en = 1'b1; bus.if_addr = 32'h40;
    t = cyc;
    sb.push_back('{1'b1, 1'b1, golden(32'h40, 4), t + 6});
    wait_ok(ok0 + 1, "fetch40_done");
    bus.if_en = 1'b0;
    step();

    // rst in the middle of a LW
    lsb_drive(1'b0, 32'h100, 32'd0, 3'd4);
    ok0 = n_ok;
    step();
    step();
    rst = 1'b1; bus.lsb_en = 1'b0;
    step();
    check("rst_mid_mem_a", bus.mem_a, 32'd0);
    check("rst_mid_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    check("rst_mid_lsb_rdata", bus.lsb_rdata, 32'd0);
    rst = 1'b0;
    repeat (5) step();
    check("rst_mid_no_ok", n_ok, ok0);
    lsb_drive(1'b0, 32'h100, 32'd0, 3'd4);
    t = cyc;
    sb.push_back('{1'b0, 1'b1, 32'h4433_2211, t + 6});
    wait_ok(ok0 + 1, "relw_done");
    bus.lsb_en = 1'b0;
    step();

    // SW with rdy low for two cycles after the first byte
    wr_log.delete();
    lsb_drive(1'b1, 32'h400, 32'h0102_0304, 3'd4);
    t = cyc;
    sb.push_back('{1'b0, 1'b0, 32'd0, t + 7});
    step();
    step();
    rdy = 1'b0;
    step();
    step();
    rdy = 1'b1;
    wait_ok(n_ok + 1, "sw_rdy_done");
    bus.lsb_en = 1'b0;
    check("sw_nwrites", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      check("sw_w0", {wr_log[0].cyc[15:0], wr_log[0].a[7:0], wr_log[0].d},
            {t[15:0] + 16'd1, 8'h00, 8'h04});
      check("sw_w1", {wr_log[1].cyc[15:0], wr_log[1].a[7:0], wr_log[1].d},
            {t[15:0] + 16'd4, 8'h01, 8'h03});
      check("sw_w3", {wr_log[3].cyc[15:0], wr_log[3].a[7:0], wr_log[3].d},
            {t[15:0] + 16'd6, 8'h03, 8'h01});
    end
    step();
    lsb_drive(1'b0, 32'h400, 32'd0, 3'd4);
    t = cyc;
    sb.push_back('{1'b0, 1'b1, 32'h0102_0304, t + 6});
    wait_ok(n_ok + 1, "lw400_done");
    bus.lsb_en = 1'b0;
    step();

`ifdef MEM_CTRL_IO_STALL_EN
    // SB to IO while the TX buffer is full for five cycles
    wr_log.delete();
    io_buffer_full = 1'b1;
    lsb_drive(1'b1, 32'h0003_0000, 32'h0000_0077, 3'd1);
    t = cyc;
    sb.push_back('{1'b0, 1'b0, 32'd0, t + 7});
    repeat (5) step();
    check("io_no_wr_stall", wr_log.size(), 0);
    step();
    io_buffer_full = 1'b0;
    wait_ok(n_ok + 1, "io_done");
    bus.lsb_en = 1'b0;
    check("io_nwrites", wr_log.size(), 1);
    if (wr_log.size() == 1) check("io_wr_cyc", wr_log[0].cyc, t + 6);
    step();
`endif

    repeat (3) step();
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
